// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART tx port.
// Ports: clk, rst (async, active-high); req/req_data/req_last from requesters;
// ack/grant back to requesters; idle_ready_tx from the UART; start_tx/data_tx
// to the UART; busy while any grant is held. All outputs are registered.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int HOLDOFF_CYCLES = 2,
    parameter int MAX_PKT_LEN    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     grant,
    input  logic                   idle_ready_tx,
    output logic                   start_tx,
    output logic [7:0]             data_tx,
    output logic                   busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_READY,
        HOLDOFF
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      owner, owner_n;
    logic [IW-1:0]      rr, rr_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [HW-1:0]      hcnt, hcnt_n;
    logic               is_last, is_last_n;
    logic [NUM_REQ-1:0] grant_n, ack_n;
    logic               start_n;
    logic [7:0]         data_n;

    logic               cur_req, cur_last;
    logic [7:0]         cur_data;
    logic               found;
    logic [IW-1:0]      pick;

    // Owner's view of the request bundle.
    always_comb begin
        cur_req  = 1'b0;
        cur_last = 1'b0;
        cur_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                cur_req  = req[i];
                cur_last = req_last[i];
                cur_data = req_data[8*i +: 8];
            end
        end
    end

    // Round-robin search: first requester above rr, then wrap to 0..rr.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IW'(i) > rr)) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IW'(i) <= rr)) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        rr_n      = rr;
        cnt_n     = cnt;
        hcnt_n    = hcnt;
        is_last_n = is_last;
        grant_n   = grant;
        ack_n     = '0;
        start_n   = 1'b0;
        data_n    = data_tx;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_n       = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    cnt_n         = '0;
                    state_n       = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (!cur_req) begin
                    grant_n = '0;
                    rr_n    = owner;
                    state_n = IDLE;
                end else if (idle_ready_tx) begin
                    start_n   = 1'b1;
                    data_n    = cur_data;
                    ack_n     = grant;
                    // The fairness cap closes the packet like req_last does.
                    is_last_n = cur_last ||
                                (cnt + CW'(1) == CW'(MAX_PKT_LEN));
                    cnt_n     = cnt + CW'(1);
                    hcnt_n    = '0;
                    state_n   = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // The start_tx cycle plus HOLDOFF_CYCLES more are spent here.
                if (hcnt == HW'(HOLDOFF_CYCLES)) begin
                    if (is_last) begin
                        grant_n = '0;
                        rr_n    = owner;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT_READY;
                    end
                end else begin
                    hcnt_n = hcnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr       <= IW'(NUM_REQ - 1);
            cnt      <= '0;
            hcnt     <= '0;
            is_last  <= 1'b0;
            grant    <= '0;
            ack      <= '0;
            start_tx <= 1'b0;
            data_tx  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr       <= rr_n;
            cnt      <= cnt_n;
            hcnt     <= hcnt_n;
            is_last  <= is_last_n;
            grant    <= grant_n;
            ack      <= ack_n;
            start_tx <= start_n;
            data_tx  <= data_n;
            busy     <= |grant_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the UART tx arbiter.
// A per-cycle vector table plus reactive requester models for the multi-cycle cases.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_last = '0;
    logic        rdy = 1'b0;

    logic [2:0]  ack, grant, ack4, grant4;
    logic        start_tx, busy, start4, busy4;
    logic [7:0]  data_tx, data4;

    logic        use4 = 1'b0;
    logic [2:0]  s_ack, s_grant;
    logic        s_start, s_busy;
    logic [7:0]  s_data;

    assign s_ack   = use4 ? ack4   : ack;
    assign s_grant = use4 ? grant4 : grant;
    assign s_start = use4 ? start4 : start_tx;
    assign s_busy  = use4 ? busy4  : busy;
    assign s_data  = use4 ? data4  : data_tx;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(3), .HOLDOFF_CYCLES(2), .MAX_PKT_LEN(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack), .grant(grant),
        .idle_ready_tx(rdy), .start_tx(start_tx), .data_tx(data_tx),
        .busy(busy)
    );

    uart_tx_arbiter #(
        .NUM_REQ(3), .HOLDOFF_CYCLES(2), .MAX_PKT_LEN(4)
    ) dut4 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack4), .grant(grant4),
        .idle_ready_tx(rdy), .start_tx(start4), .data_tx(data4),
        .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] req;
        logic [7:0] d0;
        logic       l0;
        logic       rdy;
        logic [2:0] e_grant;
        logic       e_start;
        logic [2:0] e_ack;
        logic [7:0] e_data;
        logic       e_busy;
    } vec_t;

    vec_t tv [15];

    // Requester models: per-requester byte queues, popped on ack.
    logic [7:0] qd [3][8];
    logic       ql [3][8];
    int         qlen [3];
    int         qhd [3];
    logic [2:0] en;
    int         cyc;

    int         st_n, gr_n;
    int         st_own [32];
    logic [7:0] st_dat [32];
    int         st_cyc [32];
    int         gr_own [32];
    int         gr_cyc [32];
    logic [2:0] prev_grant;

    function automatic int idx_of(input logic [2:0] g);
        for (int i = 0; i < 3; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic push(input int i, input logic [7:0] d, input logic l);
        qd[i][qlen[i]] = d;
        ql[i][qlen[i]] = l;
        qlen[i]++;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            if (en[i] && qhd[i] < qlen[i]) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = qd[i][qhd[i]];
                req_last[i]       = ql[i][qhd[i]];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        chk("inv_start_grant",
            32'(s_start && (s_grant == 3'b000)), 32'd0);
        chk("inv_ack", 32'(s_ack), 32'(s_start ? s_grant : 3'b000));
        chk("inv_busy", 32'(s_busy), 32'(|s_grant));
        if (s_start && st_n < 32) begin
            st_own[st_n] = idx_of(s_grant);
            st_dat[st_n] = s_data;
            st_cyc[st_n] = cyc;
            st_n++;
        end
        if (s_grant != 3'b000 && s_grant != prev_grant && gr_n < 32) begin
            gr_own[gr_n] = idx_of(s_grant);
            gr_cyc[gr_n] = cyc;
            gr_n++;
        end
        prev_grant = s_grant;
        for (int i = 0; i < 3; i++)
            if (s_ack[i] && qhd[i] < qlen[i]) qhd[i]++;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = '0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        rdy      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            qlen[i] = 0;
            qhd[i]  = 0;
        end
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        cyc        = 0;
        st_n       = 0;
        gr_n       = 0;
        prev_grant = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        int o2 [6];
        logic [7:0] d2 [6];
        int o5 [7];
        logic [7:0] d5 [7];
        logic seen;

        // req, d0, l0, rdy | grant, start, ack, data, busy
        tv[0]  = '{3'b001, 8'h41, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0};
        tv[1]  = '{3'b001, 8'h41, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 8'h00, 1'b1};
        tv[2]  = '{3'b001, 8'h41, 1'b0, 1'b1, 3'b001, 1'b1, 3'b001, 8'h41, 1'b1};
        tv[3]  = '{3'b001, 8'h42, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 8'h41, 1'b1};
        tv[4]  = '{3'b001, 8'h42, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 8'h41, 1'b1};
        tv[5]  = '{3'b001, 8'h42, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 8'h41, 1'b1};
        tv[6]  = '{3'b001, 8'h42, 1'b0, 1'b1, 3'b001, 1'b1, 3'b001, 8'h42, 1'b1};
        tv[7]  = '{3'b001, 8'h43, 1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 8'h42, 1'b1};
        tv[8]  = '{3'b001, 8'h43, 1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 8'h42, 1'b1};
        tv[9]  = '{3'b001, 8'h43, 1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 8'h42, 1'b1};
        tv[10] = '{3'b001, 8'h43, 1'b1, 1'b1, 3'b001, 1'b1, 3'b001, 8'h43, 1'b1};
        tv[11] = '{3'b000, 8'h00, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 8'h43, 1'b1};
        tv[12] = '{3'b000, 8'h00, 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 8'h43, 1'b1};
        tv[13] = '{3'b011, 8'h00, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 8'h43, 1'b0};
        tv[14] = '{3'b011, 8'h00, 1'b0, 1'b1, 3'b010, 1'b0, 3'b000, 8'h43, 1'b1};

        o2 = '{0, 1, 2, 0, 1, 2};
        d2 = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
        o5 = '{1, 1, 1, 1, 2, 1, 1};
        d5 = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h99, 8'h84, 8'h85};

        // Test 1: single requester, 3-byte packet, then rr check.
        do_reset();
        chk("rst_data_tx", 32'(data_tx), 32'd0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("t1_grant[%0d]", k), 32'(grant), 32'(tv[k].e_grant));
            chk($sformatf("t1_start[%0d]", k), 32'(start_tx), 32'(tv[k].e_start));
            chk($sformatf("t1_ack[%0d]", k), 32'(ack), 32'(tv[k].e_ack));
            chk($sformatf("t1_data[%0d]", k), 32'(data_tx), 32'(tv[k].e_data));
            chk($sformatf("t1_busy[%0d]", k), 32'(busy), 32'(tv[k].e_busy));
            req      = tv[k].req;
            req_data = {16'h0000, tv[k].d0};
            req_last = {2'b00, tv[k].l0};
            rdy      = tv[k].rdy;
        end

        // Test 2: all three request, 1-byte packets, each re-requests once.
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(i, 8'(8'h10 * (i + 1)), 1'b1);
            push(i, 8'(8'h10 * (i + 1) + 1), 1'b1);
        end
        en = 3'b111;
        drive_inputs();
        run(40);
        chk("t2_starts", 32'(st_n), 32'd6);
        chk("t2_grants", 32'(gr_n), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_gown[%0d]", k), 32'(gr_own[k]), 32'(o2[k]));
            chk($sformatf("t2_sown[%0d]", k), 32'(st_own[k]), 32'(o2[k]));
            chk($sformatf("t2_sdat[%0d]", k), 32'(st_dat[k]), 32'(d2[k]));
        end

        // Test 3: req[1] arrives mid-packet and waits for the whole packet.
        do_reset();
        rdy = 1'b1;
        push(0, 8'h30, 1'b0);
        push(0, 8'h31, 1'b0);
        push(0, 8'h32, 1'b0);
        push(0, 8'h33, 1'b1);
        push(1, 8'h55, 1'b1);
        en = 3'b001;
        drive_inputs();
        for (int k = 0; k < 40; k++) begin
            step();
            if (st_n >= 2) en = 3'b011;
        end
        chk("t3_starts", 32'(st_n), 32'd5);
        chk("t3_first_start_cyc", 32'(st_cyc[0]), 32'd2);
        chk("t3_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_own[%0d]", k), 32'(st_own[k]), 32'd0);
            chk($sformatf("t3_dat[%0d]", k), 32'(st_dat[k]), 32'(8'h30 + k));
        end
        chk("t3_own[4]", 32'(st_own[4]), 32'd1);
        chk("t3_dat[4]", 32'(st_dat[4]), 32'h55);
        chk("t3_grants", 32'(gr_n), 32'd2);
        chk("t3_g1_own", 32'(gr_own[1]), 32'd1);
        chk("t3_g1_delay", 32'(gr_cyc[1] - st_cyc[3]), 32'd4);

        // Test 4: owner drops req in WAIT_READY; req[2] takes over.
        do_reset();
        push(0, 8'h66, 1'b1);
        push(2, 8'h77, 1'b1);
        en = 3'b101;
        drive_inputs();
        step();
        chk("t4_grant0", 32'(grant), 32'b001);
        en = 3'b100;
        drive_inputs();
        step();
        chk("t4_released", 32'(grant), 32'b000);
        en = 3'b101;
        drive_inputs();
        step();
        chk("t4_grant2", 32'(grant), 32'b100);
        rdy = 1'b1;
        run(12);
        chk("t4_starts", 32'(st_n), 32'd2);
        chk("t4_first_cyc", 32'(st_cyc[0]), 32'd4);
        chk("t4_own0", 32'(st_own[0]), 32'd2);
        chk("t4_dat0", 32'(st_dat[0]), 32'h77);
        chk("t4_own1", 32'(st_own[1]), 32'd0);
        chk("t4_dat1", 32'(st_dat[1]), 32'h66);

        // Test 5: MAX_PKT_LEN=4 forces release of an endless packet.
        do_reset();
        use4 = 1'b1;
        rdy  = 1'b1;
        for (int k = 0; k < 6; k++) push(1, 8'(8'h80 + k), 1'b0);
        push(2, 8'h99, 1'b1);
        en = 3'b110;
        drive_inputs();
        run(60);
        chk("t5_starts", 32'(st_n), 32'd7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t5_own[%0d]", k), 32'(st_own[k]), 32'(o5[k]));
            chk($sformatf("t5_dat[%0d]", k), 32'(st_dat[k]), 32'(d5[k]));
        end
        chk("t5_idle_end", 32'(grant4), 32'd0);
        use4 = 1'b0;

        // Test 6: reset while start_tx is high cuts it at once.
        do_reset();
        rdy = 1'b1;
        push(0, 8'h11, 1'b1);
        en = 3'b001;
        drive_inputs();
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            seen = start_tx;
        end
        chk("t6_start_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_start", 32'(start_tx), 32'd0);
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_data", 32'(data_tx), 32'd0);
        do_reset();
        rdy = 1'b1;
        push(0, 8'h10, 1'b1);
        push(1, 8'h21, 1'b1);
        push(2, 8'h22, 1'b1);
        en = 3'b110;
        drive_inputs();
        run(20);
        chk("t6_g_own", 32'(gr_own[0]), 32'd1);
        chk("t6_g_cyc", 32'(gr_cyc[0]), 32'd1);
        chk("t6_starts", 32'(st_n), 32'd2);
        chk("t6_own0", 32'(st_own[0]), 32'd1);
        chk("t6_dat0", 32'(st_dat[0]), 32'h21);
        chk("t6_own1", 32'(st_own[1]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
